// File: rtl/loop_datapath_pkg.sv
// Shared constants for the loop datapath: state indices of the one-hot
// control vector and the default widths.
package loop_datapath_pkg;

  localparam int NUM_STATES     = 7;
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_CNT_W  = 8;

  // Bit positions of each controller state inside the control vector
  localparam int S0 = 0;
  localparam int S1 = 1;
  localparam int S2 = 2;
  localparam int S3 = 3;
  localparam int S4 = 4;
  localparam int S5 = 5;
  localparam int S6 = 6;

  typedef logic [NUM_STATES-1:0] ctrl_vec_t;

endpackage

// File: rtl/loop_datapath_onehot_check.sv
// Legality test for the controller's state vector: exactly one bit high.
module ld_onehot_check
  import loop_datapath_pkg::*;
#(
  parameter int N = NUM_STATES
) (
  input  logic [N-1:0] vec,
  output logic         legal
);

  // Non-zero with no second bit set: clearing the lowest set bit must leave zero
  always_comb begin
    legal = (vec != '0) && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/loop_datapath.sv
// Loop datapath driven by a one-hot controller: latches a trip count,
// accumulates an operand stream and publishes the sum with a valid pulse.
// Optional feature: define LOOP_DATAPATH_ONEHOT_CHECK_EN to get a sticky
// ctrl_error flag for illegal control vectors; otherwise ctrl_error is 0.
module loop_datapath
  import loop_datapath_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_ctrl_in,
  input  logic              s1_ctrl_in,
  input  logic              s2_ctrl_in,
  input  logic              s3_ctrl_in,
  input  logic              s4_ctrl_in,
  input  logic              s5_ctrl_in,
  input  logic              s6_ctrl_in,
  input  logic [CNT_W-1:0]  trip_count,
  input  logic [DATA_W-1:0] data_in,
  output logic              B_ctrl_out0,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              ctrl_error
);

  ctrl_vec_t ctrl_vec;
  logic      ctrl_legal;

  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  trip_q, trip_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;

  assign ctrl_vec = {s6_ctrl_in, s5_ctrl_in, s4_ctrl_in, s3_ctrl_in,
                     s2_ctrl_in, s1_ctrl_in, s0_ctrl_in};

  // Illegal vectors freeze every register, so this check gates updates
  // whether or not the error flag is built.
  ld_onehot_check #(.N(NUM_STATES)) u_onehot_check (
    .vec   (ctrl_vec),
    .legal (ctrl_legal)
  );

  // Next-state values: hold by default, act only on a legal one-hot vector
  always_comb begin
    idx_d          = idx_q;
    trip_d         = trip_q;
    acc_d          = acc_q;
    op_d           = op_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    if (ctrl_legal) begin
      if (ctrl_vec[S1]) begin
        idx_d  = '0;
        acc_d  = '0;
        trip_d = trip_count;
      end
      if (ctrl_vec[S2]) op_d = data_in;
      if (ctrl_vec[S3]) acc_d = acc_q + op_q;
      if (ctrl_vec[S4]) idx_d = idx_q + CNT_W'(1);
      if (ctrl_vec[S5]) result_d = acc_q;
      if (ctrl_vec[S6]) result_valid_d = 1'b1;
    end
  end

  // Datapath registers with synchronous reset taking priority over controls
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q          <= '0;
      trip_q         <= '0;
      acc_q          <= '0;
      op_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      trip_q         <= trip_d;
      acc_q          <= acc_d;
      op_q           <= op_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Loop-continue condition from registered values; wraps with idx, and a
  // zero trip count gets no special treatment here
  always_comb begin
    B_ctrl_out0 = ((idx_q + CNT_W'(1)) != trip_q);
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

`ifdef LOOP_DATAPATH_ONEHOT_CHECK_EN
  logic ctrl_error_q, ctrl_error_d;

  // Sticky error: any illegal vector outside reset sets it until reset
  always_comb begin
    ctrl_error_d = ctrl_error_q | ~ctrl_legal;
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) ctrl_error_q <= 1'b0;
    else       ctrl_error_q <= ctrl_error_d;
  end

  assign ctrl_error = ctrl_error_q;
`else
  assign ctrl_error = 1'b0;
`endif

endmodule

// File: doc/loop_datapath.md
LOOP_DATAPATH -- requirements
Module: loop_datapath

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, data and accumulator width.
REQ-002 The block SHALL have parameter CNT_W, default 8, loop index and trip-count width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports s0_ctrl_in..s6_ctrl_in, input, 1 each, one-hot state controls from the controller FSM.
REQ-006 The block SHALL have port trip_count, input, CNT_W, loop iteration count, sampled in s1.
REQ-007 The block SHALL have port data_in, input, DATA_W, operand stream, sampled in s2.
REQ-008 The block SHALL have port B_ctrl_out0, output, 1, loop-continue condition returned to the controller.
REQ-009 The block SHALL have port result, output, DATA_W, final accumulated sum.
REQ-010 The block SHALL have port result_valid, output, 1, single-cycle pulse marking result update.
REQ-011 The block SHALL have port ctrl_error, output, 1, sticky flag for an illegal control vector.

Function
REQ-012 In a cycle with only s0 high, the block SHALL hold all registers unchanged (idle).
REQ-013 In a cycle with only s1 high, the block SHALL clear idx and acc to 0 and latch trip_count into trip_reg.
REQ-014 In a cycle with only s2 high, the block SHALL latch data_in into op_reg.
REQ-015 In a cycle with only s3 high, the block SHALL update acc <= acc + op_reg, modulo 2^DATA_W with carry discarded.
REQ-016 In a cycle with only s4 high, the block SHALL update idx <= idx + 1, modulo 2^CNT_W.
REQ-017 In a cycle with only s5 high, the block SHALL update result <= acc.
REQ-018 In a cycle with only s6 high, the block SHALL assert result_valid for the following cycle only.
REQ-019 B_ctrl_out0 SHALL be combinational and equal (idx + 1 != trip_reg) from registered values: 1 means loop back to s2, 0 means exit to s5; the controller samples it in s4.
REQ-020 With trip_count = 0 latched, B_ctrl_out0 SHALL be computed exactly as in REQ-019, with no special casing; the controller is responsible for skipping the loop, and the block does not enforce it.
REQ-021 Revisiting s1 mid-loop SHALL restart the loop: idx and acc are cleared and trip_reg is re-latched.
REQ-022 In a cycle where the control vector is not exactly one-hot (zero or multiple bits high), the block SHALL update no registers; result_valid SHALL be 0 the next cycle.
REQ-023 result SHALL hold its value until the next s5 or reset.

Reset
REQ-024 While reset is high at a rising edge, the block SHALL clear idx, acc, op_reg, trip_reg, result, result_valid and ctrl_error to 0.
REQ-025 Reset SHALL take priority over every control input, including mid-loop; B_ctrl_out0 is then 1 (0 + 1 != 0).
REQ-026 Control inputs SHALL be ignored for error detection during reset cycles.

Configuration
REQ-027 With macro LOOP_DATAPATH_ONEHOT_CHECK_EN defined, ctrl_error SHALL set on any non-reset cycle violating REQ-022 and remain set until reset.
REQ-028 Without LOOP_DATAPATH_ONEHOT_CHECK_EN, ctrl_error SHALL be tied to 0 and the check logic omitted; REQ-022 register gating still applies.

Structure
REQ-029 Package loop_datapath_pkg SHALL hold the state-index constants S0..S6, NUM_STATES = 7, and the default DATA_W/CNT_W values.
REQ-030 The one-hot legality test SHALL be the sub-module ld_onehot_check (NUM_STATES-bit vector in, legal out); it is instantiated for register gating regardless of the macro.

Verification
REQ-031 Reset, then s1 with trip_count=3, loop s2/s3/s4 with data_in=5,7,9, then s5, s6 -> B_ctrl_out0 reads 1,1,0 in the three s4 cycles; result=21; result_valid high exactly one cycle after s6.
REQ-032 DATA_W=16; accumulate 0xFFFF then 0x0002 -> result=0x0001 (wrap, no error).
REQ-033 Mid-loop (idx=2, acc=40) assert reset one cycle -> all registers 0 next cycle, B_ctrl_out0=1, result=0.
REQ-034 With the macro on, drive s2 and s3 high together with data_in=0x1234 -> op_reg and acc unchanged, ctrl_error=1 and sticky until reset; with the macro off, ctrl_error stays 0.
REQ-035 With trip_count=1, s1 then s2 (data_in=4), s3, s4 -> B_ctrl_out0=0 during s4; after s5, result=4.
REQ-036 Re-enter s1 with trip_count=2 after one iteration -> idx=0, acc=0; a fresh two-iteration run with data_in=10,20 gives result=30.
